div: RTL and testbench
======================

Name: div

Overview:
Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. It is the responder side of the start/ready handshake that the execute stage initiates; it holds the request while the pipeline stalls via ctrl. It returns {remainder, quotient} for the HI/LO write, which travels through ex_mem. Restoring algorithm, one quotient bit per cycle.

Parameters:
DIV_W, 32, operand width; result is 2*DIV_W; iteration count equals DIV_W.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high (`RstEnable = 1'b1)
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  input  DIV_W  dividend
opdata2_i  input  DIV_W  divisor
start_i  input  1  request; execute holds it high until it sees ready_o
annul_i  input  1  abort in-flight division (exception/flush)
result_o  output  2*DIV_W  [63:32] remainder (HI), [31:0] quotient (LO)
ready_o  output  1  result valid

Behaviour:
- Reset (rst=1 at an edge, dominates all else, including mid-operation): state=DivFree, cnt=0, ready_o=0, result_o=0, working regs=0.
- FSM states: DivFree, DivByZero, DivOn, DivEnd.
- DivFree: if start_i=1 and annul_i=0:
  - opdata2_i==0 -> DivByZero.
  - else -> DivOn with cnt=0. Latch magnitudes: if signed_div_i and operand[31]=1, use the two's complement; else use the raw value. Also latch the sign flags and signed_div_i.
  - Otherwise stay in DivFree; ready_o=0, result_o=0.
- DivByZero: next edge -> DivEnd, result_o=0, ready_o=1.
- DivOn, annul_i=1: -> DivFree, cnt=0, ready_o=0, result_o=0.
- DivOn, cnt<DIV_W: one iteration, then cnt++.
  - Partial remainder R (DIV_W+1 bits) and quotient Q.
  - R'={R[DIV_W-1:0],Q[MSB]}, Q shifted left.
  - If R'>=divisor: R'-=divisor, new Q LSB=1; else LSB=0.
- DivOn, cnt==DIV_W: apply sign fix.
  - Quotient negated iff signed and dividend sign != divisor sign.
  - Remainder negated iff signed and dividend negative.
  - Register result_o={rem,quot}, ready_o=1, -> DivEnd.
- Latency: start sampled at edge E0; ready_o high after edge E(DIV_W+1) = 33 cycles. Divide-by-zero: ready after 2 edges.
- DivEnd: result_o/ready_o held stable while start_i=1. When start_i=0 at an edge -> DivFree, ready_o=0, result_o=0.
- annul_i is ignored in DivEnd; execute simply drops start_i.
- Operand changes on opdata*_i after the DivFree sample have no effect.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF yields Q=0x80000000, R=0 (wraps, no trap).
- Arithmetic: subtraction width DIV_W+1, so the borrow is the compare result. All negation is modulo 2^DIV_W.

Decomposition:
- defines.v gains: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
- defines.v also gains: DivResultReady 1'b1, DivResultNotReady 1'b0, DivStart 1'b1, DivStop 1'b0.
- Reuse existing RstEnable, ZeroWord, RegBus, DoubleRegBus.
- No sub-module; the iteration step and sign fix stay inline (about 150 lines).

Test Plan:
1. Unsigned 100/7, start held -> ready_o rises 33 cycles after the start edge; result_o=0x00000002_0000000E.
2. Signed -7/2 (0xFFFFFFF9/0x2) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
3. Divisor 0 (0x1234/0) -> ready_o after 2 edges, result_o=0. Drop start -> next edge ready_o=0.
4. Annul at cnt=10 -> ready_o never rises, FSM back in DivFree. Next, unsigned 0xFFFFFFFF/0x10 -> result_o=0x0000000F_0FFFFFFF.
5. Hold start_i 5 cycles past ready -> result_o/ready_o constant throughout. Deassert -> next edge ready_o=0, result_o=0. Signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
6. rst=1 at cnt=20 -> next edge all outputs 0, state DivFree. A fresh start completes correctly (e.g. 9/3 -> 0x00000000_00000003).

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider.
// Holds the legacy-compatible FSM state encodings, handshake levels and
// common bus widths used by the execute-stage divider.
package div_pkg;

  // Reset level and shared bus widths.
  localparam logic        RstEnable    = 1'b1;
  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  // Divider FSM state encodings.
  typedef logic [1:0] div_state_t;
  localparam div_state_t DivFree   = 2'b00;
  localparam div_state_t DivByZero = 2'b01;
  localparam div_state_t DivOn     = 2'b10;
  localparam div_state_t DivEnd    = 2'b11;

  // Handshake levels.
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div.sv
// Multi-cycle restoring integer divider for DIV/DIVU.
// One quotient bit per cycle; DIV_W iterations plus one sign-fix cycle.
// Ports:
//   clk          - clock, all state on rising edge
//   rst          - synchronous active-high reset
//   signed_div_i - 1 = signed divide, 0 = unsigned
//   opdata1_i    - dividend
//   opdata2_i    - divisor
//   start_i      - request, held high until ready_o is seen
//   annul_i      - abort an in-flight division
//   result_o     - {remainder, quotient}
//   ready_o      - result valid; held while start_i stays high
module div
  import div_pkg::*;
#(
  parameter int unsigned DIV_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [DIV_W-1:0]   opdata1_i,
  input  logic [DIV_W-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*DIV_W-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned      CntW    = $clog2(DIV_W + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(DIV_W);
  localparam logic [CntW-1:0]  CntOne  = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] OneW    = {{(DIV_W-1){1'b0}}, 1'b1};

  div_state_t           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DIV_W:0]       rem_q, rem_d;       // partial remainder, one guard bit
  logic [DIV_W-1:0]     quot_q, quot_d;     // dividend shifts out as quotient shifts in
  logic [DIV_W-1:0]     divisor_q, divisor_d;
  logic                 sign1_q, sign1_d;
  logic                 sign2_q, sign2_d;
  logic                 signed_q, signed_d;
  logic [2*DIV_W-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 op1_neg, op2_neg;
  logic [DIV_W-1:0]     op1_mag, op2_mag;
  logic [DIV_W:0]       rem_shift, rem_diff;
  logic [DIV_W-1:0]     quot_fix, rem_fix;

  // Operand magnitudes, only meaningful when sampled in DivFree.
  always_comb begin
    op1_neg = signed_div_i & opdata1_i[DIV_W-1];
    op2_neg = signed_div_i & opdata2_i[DIV_W-1];
    op1_mag = op1_neg ? (~opdata1_i + OneW) : opdata1_i;
    op2_mag = op2_neg ? (~opdata2_i + OneW) : opdata2_i;
  end

  // One restoring step; the top bit of the DIV_W+1 wide difference is the
  // borrow, so it doubles as the "remainder < divisor" compare.
  always_comb begin
    rem_shift = {rem_q[DIV_W-1:0], quot_q[DIV_W-1]};
    rem_diff  = rem_shift - {1'b0, divisor_q};
  end

  // Sign correction applied to the final magnitudes.
  always_comb begin
    quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~quot_q + OneW) : quot_q;
    rem_fix  = (signed_q && sign1_q) ? (~rem_q[DIV_W-1:0] + OneW) : rem_q[DIV_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            rem_d     = '0;
            quot_d    = op1_mag;
            divisor_d = op2_mag;
            sign1_d   = op1_neg;
            sign2_d   = op2_neg;
            signed_d  = signed_div_i;
          end
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q != CntLast) begin
          cnt_d = cnt_q + CntOne;
          if (!rem_diff[DIV_W]) begin
            rem_d  = rem_diff;
            quot_d = {quot_q[DIV_W-2:0], 1'b1};
          end else begin
            rem_d  = rem_shift;
            quot_d = {quot_q[DIV_W-2:0], 1'b0};
          end
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
        end
      end

      DivEnd: begin
        // annul_i is deliberately ignored; execute releases us by dropping start_i.
        if (start_i == DivStop) begin
          state_d  = DivFree;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver pushes hand-computed results into a
// queue, a monitor pops and compares on every rising ready_o.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [63:0] exp_q[$];
  logic        ready_prev;

  div #(.DIV_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each new result against the oldest expectation.
  initial begin
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && ready_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", {63'd0, ready_o}, 64'd0);
        end else begin
          check("result", result_o, exp_q.pop_front());
        end
      end
      ready_prev = ready_o;
    end
  end

  // Issue one division, hold start for `hold` cycles past ready, then release.
  // exp_edges counts rising edges from the start-sampling edge up to and
  // including the one that raises ready_o.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_edges, input int hold);
    int  n;
    logic got;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        // Operands must already be captured.
        opdata1_i = ~a;
        opdata2_i = 32'h5;
      end
      got = ready_o;
    end
    check("latency", 64'(n), 64'(exp_edges));
    if (!got) void'(exp_q.pop_back());
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold", {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
      check("hold_msb", {63'd0, result_o[63]}, {63'd0, exp[63]});
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check("release_ready", {63'd0, ready_o}, 64'd0);
    check("release_result", result_o, 64'd0);
  endtask

  initial begin
    logic seen;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;

    // Basic unsigned and signed cases.
    run_op(1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 34, 0);
    run_op(1'b1, 32'hFFFFFFF9,  32'h2,        64'hFFFFFFFF_FFFFFFFD, 34, 0);
    run_op(1'b1, 32'h7,         32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 0);
    run_op(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34, 0);
    run_op(1'b0, 32'h80000000,  32'hFFFFFFFF, 64'h80000000_00000000, 34, 0);

    // Divide by zero.
    run_op(1'b0, 32'h1234,      32'h0,        64'h0, 2, 0);

    // Annul mid-operation: no result must appear.
    @(posedge clk); #1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0 || result_o !== 64'd0) seen = 1'b1;
    end
    check("annul_quiet", {63'd0, seen}, 64'd0);
    run_op(1'b0, 32'hFFFFFFFF,  32'h10,       64'h0000000F_0FFFFFFF, 34, 0);

    // Hold start past ready, then the signed overflow case.
    run_op(1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 34, 5);
    run_op(1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 34, 0);

    // Reset mid-operation.
    @(posedge clk); #1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h12345678;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_ready", {63'd0, ready_o}, 64'd0);
    check("midreset_result", result_o, 64'd0);
    run_op(1'b0, 32'd9,         32'd3,        64'h00000000_00000003, 34, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
